// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin owner selection for the shared 32-bit system bus.
// Grants are one-hot and registered. Each tenure is followed by one turnaround
// cycle. An optional wait-state watchdog is compiled in when BUS_ARB_WATCHDOG_EN
// is defined. That watchdog revokes a tenure stalled on WAIT and masks the owner
// until it drops its request.
module bus_rr_arbiter #(
    parameter int NUM_DEVICES    = 8,
    parameter int ID_WIDTH       = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DEVICES-1:0] req,
    input  logic                   bus_wait,
    output logic [NUM_DEVICES-1:0] grant,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic                   bus_idle,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [NUM_DEVICES-1:0] grant_reg, grant_next;
    logic [ID_WIDTH-1:0]    grant_id_reg, grant_id_next;
    logic [ID_WIDTH-1:0]    last_reg, last_next;
    logic                   bus_idle_reg, bus_idle_next;

    logic [NUM_DEVICES-1:0] ereq;
    logic                   owner_req;
    logic [ID_WIDTH-1:0]    cand_idx [NUM_DEVICES];
    logic [NUM_DEVICES-1:0] cand_hit;
    logic [ID_WIDTH-1:0]    sel_idx;
    logic                   sel_valid;
    logic [NUM_DEVICES-1:0] sel_onehot;
    logic                   wd_fire;

`ifdef BUS_ARB_WATCHDOG_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WCNT_W-1:0]      wcnt_reg, wcnt_next;
    logic [NUM_DEVICES-1:0] mask_reg, mask_next;
    logic                   timeout_reg, timeout_next;
    logic [NUM_DEVICES-1:0] owner_onehot;

    // A timed-out master stays excluded until it releases its request.
    assign ereq = req & ~mask_reg;

    // The revoke fires on the edge that would make wcnt reach the limit.
    assign wd_fire = (state_reg == ST_OWNED) && owner_req && bus_wait &&
                     (wcnt_reg == WCNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog, WAIT has no effect and TIMEOUT_CYCLES is not used.
    logic unused_cfg;
    assign unused_cfg = ^{bus_wait, 16'(TIMEOUT_CYCLES)};

    assign ereq    = req;
    assign wd_fire = 1'b0;
`endif

    assign owner_req = req[grant_id_reg];

    // Rotated scan order: candidate gi is master (last + 1 + gi) mod NUM_DEVICES.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEVICES; gi++) begin : g_cand
            logic [ID_WIDTH:0] sum_w;
            assign sum_w = {1'b0, last_reg} + (ID_WIDTH + 1)'(gi + 1);
            assign cand_idx[gi] = (sum_w >= (ID_WIDTH + 1)'(NUM_DEVICES)) ?
                                  ID_WIDTH'(sum_w - (ID_WIDTH + 1)'(NUM_DEVICES)) :
                                  sum_w[ID_WIDTH-1:0];
            assign cand_hit[gi] = ereq[cand_idx[gi]];
        end
    endgenerate

    // The first hit in rotated order wins. Iterating downward leaves the lowest offset.
    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                sel_idx   = cand_idx[i];
                sel_valid = 1'b1;
            end
        end
    end

    // Decode the winning index to the one-hot grant. Also decode the owner for masking.
    generate
        for (gi = 0; gi < NUM_DEVICES; gi++) begin : g_dec
            assign sel_onehot[gi] = sel_valid && (sel_idx == ID_WIDTH'(gi));
`ifdef BUS_ARB_WATCHDOG_EN
            assign owner_onehot[gi] = (grant_id_reg == ID_WIDTH'(gi));
`endif
        end
    endgenerate

    // Tenure FSM next state. The outputs are computed here and registered below.
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        grant_id_next = grant_id_reg;
        last_next     = last_reg;
`ifdef BUS_ARB_WATCHDOG_EN
        timeout_next  = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (sel_valid) begin
                    grant_next    = sel_onehot;
                    grant_id_next = sel_idx;
                    last_next     = sel_idx;
                    state_next    = ST_OWNED;
                end
            end
            ST_OWNED: begin
                // A request drop wins over a simultaneous expiry and counts as a plain release.
                if (!owner_req) begin
                    grant_next    = '0;
                    grant_id_next = '0;
                    state_next    = ST_RELEASE;
                end else if (wd_fire) begin
                    grant_next    = '0;
                    grant_id_next = '0;
                    state_next    = ST_RELEASE;
`ifdef BUS_ARB_WATCHDOG_EN
                    timeout_next  = 1'b1;
`endif
                end
            end
            ST_RELEASE: begin
                grant_next    = '0;
                grant_id_next = '0;
                state_next    = ST_IDLE;
            end
            default: begin
                grant_next    = '0;
                grant_id_next = '0;
                state_next    = ST_IDLE;
            end
        endcase
        bus_idle_next = (state_next == ST_IDLE);
    end

    // FSM state and registered outputs. Reset clears the grant asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            last_reg     <= ID_WIDTH'(NUM_DEVICES - 1);
            bus_idle_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            grant_id_reg <= grant_id_next;
            last_reg     <= last_next;
            bus_idle_reg <= bus_idle_next;
        end
    end

`ifdef BUS_ARB_WATCHDOG_EN
    // Wait counter: it restarts at each new grant, counts WAIT cycles, and saturates.
    // Mask bits clear on a dropped request and are set on a revoke.
    always_comb begin
        wcnt_next = wcnt_reg;
        mask_next = mask_reg & req;
        if (state_reg == ST_IDLE && sel_valid) begin
            wcnt_next = '0;
        end else if (state_reg == ST_OWNED && owner_req) begin
            if (!bus_wait) begin
                wcnt_next = '0;
            end else if (wcnt_reg != WCNT_W'(TIMEOUT_CYCLES)) begin
                wcnt_next = wcnt_reg + WCNT_W'(1);
            end
        end
        if (wd_fire) begin
            mask_next = mask_next | owner_onehot;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_reg    <= '0;
            mask_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wcnt_reg    <= wcnt_next;
            mask_reg    <= mask_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    assign grant    = grant_reg;
    assign grant_id = grant_id_reg;
    assign bus_idle = bus_idle_reg;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed vectors with hand-computed expectations for bus_rr_arbiter.
// The arbiter is built with TIMEOUT_CYCLES=4. The revoke scenario runs only when
// BUS_ARB_WATCHDOG_EN is defined. Otherwise the same stimulus checks that the grant is held.
module tb_bus_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic       bus_wait = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       bus_idle;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    bus_rr_arbiter #(
        .NUM_DEVICES   (8),
        .ID_WIDTH      (3),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .bus_wait(bus_wait),
        .grant   (grant),
        .grant_id(grant_id),
        .bus_idle(bus_idle),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] g, input logic [2:0] id,
                              input logic idle, input logic to);
        check({tag, ".grant"},    32'(grant),    32'(g));
        check({tag, ".grant_id"}, 32'(grant_id), 32'(id));
        check({tag, ".bus_idle"}, 32'(bus_idle), 32'(idle));
        check({tag, ".timeout"},  32'(timeout),  32'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req      = 8'h00;
        bus_wait = 1'b0;
        reset    = 1'b1;
        #3;
        reset    = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got=expired exp=finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] cur_bit;
        logic [6:0] bw_pat;

        // Reset state.
        tick();
        tick();
        check_outs("reset", 8'h00, 3'd0, 1'b1, 1'b0);
        reset = 1'b0;
        tick();

        // A single master holds its request for 3 cycles and then releases.
        req = 8'h01;
        tick();
        check_outs("t1.own0", 8'h01, 3'd0, 1'b0, 1'b0);
        tick();
        check_outs("t1.own1", 8'h01, 3'd0, 1'b0, 1'b0);
        tick();
        check_outs("t1.own2", 8'h01, 3'd0, 1'b0, 1'b0);
        req = 8'h00;
        tick();
        check_outs("t1.release", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        check_outs("t1.idle", 8'h00, 3'd0, 1'b1, 1'b0);

        // All masters request. Each drops after one cycle of tenure, so the grant rotates.
        do_reset();
        req = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            cur_bit = 8'h01 << (i % 8);
            check_outs($sformatf("t2.g%0d", i), cur_bit, 3'(i % 8), 1'b0, 1'b0);
            req = 8'hFF & ~cur_bit;
            tick();
            check_outs($sformatf("t2.rel%0d", i), 8'h00, 3'd0, 1'b0, 1'b0);
            req = 8'hFF;
            tick();
            check_outs($sformatf("t2.idle%0d", i), 8'h00, 3'd0, 1'b1, 1'b0);
            tick();
        end

        // With last=3, master 0 beats master 3 because the scan order is 4,5,6,7,0.
        do_reset();
        req = 8'h08;
        tick();
        check_outs("t3.own3", 8'h08, 3'd3, 1'b0, 1'b0);
        req = 8'h00;
        tick();
        req = 8'h09;
        tick();
        tick();
        check_outs("t3.own0", 8'h01, 3'd0, 1'b0, 1'b0);
        req = 8'h08;
        tick();
        tick();
        tick();
        check_outs("t3.own3b", 8'h08, 3'd3, 1'b0, 1'b0);
        req = 8'h00;
        tick();
        tick();

`ifdef BUS_ARB_WATCHDOG_EN
        // Watchdog: master 2 stalls on WAIT and is revoked after the 4th edge. It stays masked.
        do_reset();
        req = 8'h04;
        tick();
        check_outs("t4.own2", 8'h04, 3'd2, 1'b0, 1'b0);
        bus_wait = 1'b1;
        req = 8'h24;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_outs($sformatf("t4.wait%0d", i), 8'h04, 3'd2, 1'b0, 1'b0);
        end
        tick();
        check_outs("t4.revoke", 8'h00, 3'd0, 1'b0, 1'b1);
        bus_wait = 1'b0;
        tick();
        check_outs("t4.idle", 8'h00, 3'd0, 1'b1, 1'b0);
        tick();
        check_outs("t4.own5", 8'h20, 3'd5, 1'b0, 1'b0);
        req = 8'h04;
        tick();
        tick();
        tick();
        check_outs("t4.masked", 8'h00, 3'd0, 1'b1, 1'b0);
        tick();
        check_outs("t4.masked2", 8'h00, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        req = 8'h04;
        tick();
        check_outs("t4.regrant2", 8'h04, 3'd2, 1'b0, 1'b0);
        req = 8'h00;
        tick();
        tick();
`else
        // No watchdog: WAIT never ends the tenure.
        do_reset();
        req = 8'h04;
        tick();
        check_outs("t4.own2", 8'h04, 3'd2, 1'b0, 1'b0);
        bus_wait = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_outs($sformatf("t4.hold%0d", i), 8'h04, 3'd2, 1'b0, 1'b0);
        end
        req = 8'h00;
        bus_wait = 1'b0;
        tick();
        tick();
`endif

        // An interrupted WAIT run restarts the count. A drop on the expiry edge is a plain release.
        do_reset();
        req = 8'h02;
        tick();
        check_outs("t5.own1", 8'h02, 3'd1, 1'b0, 1'b0);
        bw_pat = 7'b111_0111;
        for (int i = 0; i < 7; i++) begin
            bus_wait = bw_pat[6 - i];
            tick();
            check_outs($sformatf("t5.w%0d", i), 8'h02, 3'd1, 1'b0, 1'b0);
        end
        bus_wait = 1'b1;
        req = 8'h00;
        tick();
        check_outs("t5.droprel", 8'h00, 3'd0, 1'b0, 1'b0);
        bus_wait = 1'b0;
        tick();
        req = 8'h02;
        tick();
        check_outs("t5.regrant1", 8'h02, 3'd1, 1'b0, 1'b0);
        req = 8'h00;
        tick();
        tick();

        // Async reset mid-tenure clears the grant at once and restores the pointer.
        req = 8'h01;
        tick();
        check_outs("t6.own0", 8'h01, 3'd0, 1'b0, 1'b0);
        tick();
        #3;
        reset = 1'b1;
        #1;
        check_outs("t6.async", 8'h00, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        #1;
        reset = 1'b0;
        req = 8'h81;
        tick();
        check_outs("t6.first0", 8'h01, 3'd0, 1'b0, 1'b0);
        req = 8'h80;
        tick();
        tick();
        tick();
        check_outs("t6.then7", 8'h80, 3'd7, 1'b0, 1'b0);
        req = 8'h00;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
